// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer blocks: default RAM geometry and
// the dump-read state encoding used by the command processor and capture control.
package la_pkg;

    localparam int LA_ENTRIES = 384;
    localparam int LA_LOG2    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/dump_rd_ctrl_if.sv
// Bundle between the command processor / UART side (master) and the dump read
// controller (slave), including the shared RAM read address and enable.
interface dump_rd_ctrl_if #(
    parameter int LOG2 = la_pkg::LA_LOG2
);
    logic            strt_rd;
    logic            resp_sent;
    logic [LOG2-1:0] ram_addr;
    logic [LOG2-1:0] raddr;
    logic            ren;
    logic            rd_busy;
    logic            rd_done;

    modport master (
        output strt_rd, resp_sent, ram_addr,
        input  raddr, ren, rd_busy, rd_done
    );

    modport slave (
        input  strt_rd, resp_sent, ram_addr,
        output raddr, ren, rd_busy, rd_done
    );
endinterface

// File: rtl/addr_wrap_inc.sv
// Circular address increment for RAMs whose depth need not be a power of two;
// also used by the capture write-address logic.
module addr_wrap_inc #(
    parameter int ENTRIES = la_pkg::LA_ENTRIES,
    parameter int LOG2    = la_pkg::LA_LOG2
) (
    input  logic [LOG2-1:0] a,
    output logic [LOG2-1:0] nxt
);
    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    assign nxt = (a == LAST) ? '0 : a + 1'b1;
endmodule

// File: rtl/dump_rd_ctrl.sv
// Dump read sequencer: replays every RAM entry oldest-first, one read per byte
// acknowledged by the UART, starting just after the last captured address.
module dump_rd_ctrl
    import la_pkg::*;
#(
    parameter int ENTRIES = LA_ENTRIES,
    parameter int LOG2    = LA_LOG2
) (
    input  logic               clk,
    input  logic               rst_n,
    dump_rd_ctrl_if.slave      bus
);
    localparam logic [LOG2-1:0] LAST_CNT = LOG2'(ENTRIES - 1);

    rd_state_t       state_reg;
    logic [LOG2-1:0] raddr_reg;
    logic [LOG2-1:0] cnt_reg;
    logic            ren_reg;
    logic            rd_busy_reg;
    logic            rd_done_reg;

    // Slot 0 wraps the start point (ram_addr), slot 1 advances the read pointer.
    logic [LOG2-1:0] inc_in  [2];
    logic [LOG2-1:0] inc_out [2];

    assign inc_in[0] = bus.ram_addr;
    assign inc_in[1] = raddr_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_inc
            addr_wrap_inc #(
                .ENTRIES (ENTRIES),
                .LOG2    (LOG2)
            ) u_inc (
                .a   (inc_in[gi]),
                .nxt (inc_out[gi])
            );
        end
    endgenerate

    // ren is registered so that it is high for exactly the PRIME cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            raddr_reg   <= '0;
            cnt_reg     <= '0;
            ren_reg     <= 1'b0;
            rd_busy_reg <= 1'b0;
            rd_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.strt_rd) begin
                        raddr_reg   <= inc_out[0];
                        cnt_reg     <= '0;
                        rd_done_reg <= 1'b0;
                        rd_busy_reg <= 1'b1;
                        ren_reg     <= 1'b1;
                        state_reg   <= PRIME;
                    end
                end
                PRIME: begin
                    ren_reg   <= 1'b0;
                    state_reg <= SEND;
                end
                SEND: begin
                    if (bus.resp_sent) begin
                        if (cnt_reg == LAST_CNT) begin
                            rd_done_reg <= 1'b1;
                            rd_busy_reg <= 1'b0;
                            state_reg   <= DONE;
                        end else begin
                            cnt_reg   <= cnt_reg + 1'b1;
                            raddr_reg <= inc_out[1];
                            ren_reg   <= 1'b1;
                            state_reg <= PRIME;
                        end
                    end
                end
                default: begin
                    ren_reg     <= 1'b0;
                    rd_busy_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign bus.raddr   = raddr_reg;
    assign bus.ren     = ren_reg;
    assign bus.rd_busy = rd_busy_reg;
    assign bus.rd_done = rd_done_reg;
endmodule

// File: tb/tb_dump_rd_ctrl.sv
// Directed bench for dump_rd_ctrl: full dumps with wrap, ignored restarts,
// mid-dump ram_addr changes, async reset and ignored resp_sent pulses.
module tb_dump_rd_ctrl;
    import la_pkg::*;

    localparam int N  = 384;
    localparam int LW = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dump_rd_ctrl_if #(.LOG2(LW)) bus ();

    dump_rd_ctrl #(.ENTRIES(N), .LOG2(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // per-dump tallies
    int exp_addr, seq_err, ren_cnt, max_addr, last_addr, extra_ren;
    int inj_byte = -1;
    int inj_mode = 0;
    int inj_ram  = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input int ra, input bit with_resp);
        $display("dump start ram_addr=%0d resp_sent_same_cycle=%0d", ra, with_resp);
        bus.ram_addr  = ra[LW-1:0];
        bus.strt_rd   = 1'b1;
        bus.resp_sent = with_resp;
        tick();
        bus.strt_rd   = 1'b0;
        bus.resp_sent = 1'b0;
        exp_addr  = (ra + 1) % N;
        seq_err   = 0;
        ren_cnt   = 0;
        max_addr  = 0;
        last_addr = -1;
        extra_ren = 0;
    endtask

    // Serve n bytes: wait for ren, check address, idle gap cycles, then ack.
    task automatic serve(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int to = 0;
            while (bus.ren !== 1'b1 && to < 40) begin
                tick();
                to++;
            end
            if (bus.ren !== 1'b1) begin
                check_eq("ren_timeout", 0, 1);
                return;
            end
            ren_cnt++;
            if (int'(bus.raddr) != exp_addr) seq_err++;
            if (bus.rd_busy !== 1'b1) seq_err++;
            if (int'(bus.raddr) > max_addr) max_addr = int'(bus.raddr);
            last_addr = int'(bus.raddr);
            exp_addr  = (exp_addr + 1) % N;
            if (i == inj_byte) begin
                if (inj_mode == 1) begin
                    bus.strt_rd  = 1'b1;
                    bus.ram_addr = inj_ram[LW-1:0];
                end else begin
                    bus.resp_sent = 1'b1;
                end
            end
            tick();
            bus.resp_sent = 1'b0;
            for (int j = 0; j < gap; j++) begin
                if (bus.ren !== 1'b0) extra_ren++;
                tick();
                bus.strt_rd = 1'b0;
            end
            if (bus.ren !== 1'b0) extra_ren++;
            bus.resp_sent = 1'b1;
            tick();
            bus.resp_sent = 1'b0;
            if (i < n - 1 && bus.ren !== 1'b1) seq_err++;
        end
    endtask

    task automatic end_dump(input string pfx, input int last);
        $display("dump end %s reads=%0d last_raddr=%0d", pfx, ren_cnt, last_addr);
        check_eq({pfx, "_seq_err"},   seq_err, 0);
        check_eq({pfx, "_ren_cnt"},   ren_cnt, N);
        check_eq({pfx, "_extra_ren"}, extra_ren, 0);
        check_eq({pfx, "_max_lt_n"},  int'(max_addr < N), 1);
        check_eq({pfx, "_last_addr"}, last_addr, last);
        check_eq({pfx, "_rd_done"},   int'(bus.rd_done), 1);
        check_eq({pfx, "_rd_busy"},   int'(bus.rd_busy), 0);
        check_eq({pfx, "_raddr_hold"}, int'(bus.raddr), last);
        tick();
        tick();
        check_eq({pfx, "_done_hold"}, int'(bus.rd_done), 1);
        check_eq({pfx, "_ren_idle"},  int'(bus.ren), 0);
    endtask

    initial begin
        int rcnt;
        bus.strt_rd   = 1'b0;
        bus.resp_sent = 1'b0;
        bus.ram_addr  = '0;

        // reset values
        tick();
        tick();
        check_eq("rst_raddr",   int'(bus.raddr), 0);
        check_eq("rst_ren",     int'(bus.ren), 0);
        check_eq("rst_rd_busy", int'(bus.rd_busy), 0);
        check_eq("rst_rd_done", int'(bus.rd_done), 0);
        rst_n = 1'b1;
        tick();

        // resp_sent in IDLE is ignored
        bus.ram_addr = 9'd77;
        rcnt = 0;
        for (int k = 0; k < 6; k++) begin
            bus.resp_sent = k[0];
            tick();
            if (bus.ren !== 1'b0) rcnt++;
        end
        bus.resp_sent = 1'b0;
        check_eq("idle_resp_ren",   rcnt, 0);
        check_eq("idle_resp_raddr", int'(bus.raddr), 0);
        check_eq("idle_resp_busy",  int'(bus.rd_busy), 0);

        // full dump from ram_addr=5, gap 10, resp_sent also pulsed during PRIME of byte 7
        start_dump(5, 1'b0);
        check_eq("t1_first_ren",   int'(bus.ren), 1);
        check_eq("t1_first_raddr", int'(bus.raddr), 6);
        check_eq("t1_busy",        int'(bus.rd_busy), 1);
        inj_byte = 7; inj_mode = 2;
        serve(N, 10);
        inj_byte = -1;
        end_dump("t1", 5);

        // wrap corner: ram_addr=383 starts at 0
        start_dump(383, 1'b0);
        check_eq("t2a_done_drop",   int'(bus.rd_done), 0);
        check_eq("t2a_first_raddr", int'(bus.raddr), 0);
        serve(N, 1);
        end_dump("t2a", 383);

        // ram_addr=382: 383 then 0
        start_dump(382, 1'b0);
        check_eq("t2b_first_raddr", int'(bus.raddr), 383);
        serve(1, 1);
        check_eq("t2b_second_raddr", int'(bus.raddr), 0);
        serve(N - 1, 1);
        ren_cnt = ren_cnt;
        end_dump("t2b", 382);

        // restart in DONE with resp_sent in the same cycle; strt_rd + new ram_addr at byte 100 ignored
        start_dump(5, 1'b1);
        check_eq("t6_restart_done", int'(bus.rd_done), 0);
        check_eq("t6_restart_ren",  int'(bus.ren), 1);
        check_eq("t6_restart_addr", int'(bus.raddr), 6);
        inj_byte = 100; inj_mode = 1; inj_ram = 200;
        serve(N, 2);
        inj_byte = -1;
        end_dump("t3", 5);

        // strt_rd in DONE with ram_addr=0x10
        start_dump(16, 1'b0);
        check_eq("t3b_done_drop",   int'(bus.rd_done), 0);
        check_eq("t3b_first_raddr", int'(bus.raddr), 17);

        // async reset during SEND at byte 50
        serve(50, 1);
        tick();
        check_eq("t5_in_send_busy", int'(bus.rd_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_raddr",   int'(bus.raddr), 0);
        check_eq("t5_rst_ren",     int'(bus.ren), 0);
        check_eq("t5_rst_rd_busy", int'(bus.rd_busy), 0);
        check_eq("t5_rst_rd_done", int'(bus.rd_done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        rcnt = 0;
        for (int k = 0; k < 10; k++) begin
            bus.resp_sent = ~k[0];
            tick();
            if (bus.ren !== 1'b0) rcnt++;
        end
        bus.resp_sent = 1'b0;
        check_eq("t5_post_rst_ren",  rcnt, 0);
        check_eq("t5_post_rst_busy", int'(bus.rd_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
